// File: rtl/rl_queue_pkg.sv
// Shared helpers for the rl_queue scheduler: index width and round-robin search.
package rl_queue_pkg;

    localparam int MAXQ = 64;

    typedef struct packed {
        logic found;
        int   idx;
    } rr_res_t;

    function automatic int idx_w(input int n);
        return $clog2(n > 1 ? n : 2);
    endfunction

    // Scan ptr+1 .. ptr (inclusive, wrapping at nq) for the first set mask bit.
    function automatic rr_res_t next_rr(input logic [MAXQ-1:0] mask, input int ptr, input int nq);
        rr_res_t res;
        int      j;
        res = '0;
        for (int i = 1; i <= MAXQ; i++) begin
            if (i <= nq && !res.found) begin
                j = ptr + i;
                if (j >= nq) j = j - nq;
                if (mask[j[5:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rl_rr_arbiter.sv
// Combinational round-robin find-first-from-pointer over an NQ-bit request mask.
module rl_rr_arbiter
    import rl_queue_pkg::*;
#(
    parameter int NQ = 4,
    parameter int IW = idx_w(NQ)
) (
    input  logic [NQ-1:0] i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_grant_valid,
    output logic [IW-1:0] o_grant_idx
);

    logic [MAXQ-1:0] w_mask;
    rr_res_t         w_res;

    always_comb begin
        w_mask         = '0;
        w_mask[NQ-1:0] = i_req;
        w_res          = next_rr(w_mask, int'(i_ptr), NQ);
    end

    assign o_grant_valid = w_res.found;
    assign o_grant_idx   = IW'(w_res.idx);

endmodule

// File: rtl/rl_queue_sched.sv
// Round-robin burst scheduler draining NQ fall-through queues into one registered stream.
// Optional RL_QUEUE_SCHED_PRIO_EN adds prio_i to favour high-priority queues.
module rl_queue_sched
    import rl_queue_pkg::*;
#(
    parameter int NQ    = 4,
    parameter int DBITS = 32,
    parameter int BURST = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       ena_i,
    input  logic [NQ-1:0]              q_empty_i,
    input  logic [NQ-1:0][DBITS-1:0]   q_data_i,
`ifdef RL_QUEUE_SCHED_PRIO_EN
    input  logic [NQ-1:0]              prio_i,
`endif
    output logic [NQ-1:0]              q_re_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DBITS-1:0]           data_o,
    output logic [idx_w(NQ)-1:0]       src_o
);

    localparam int IW = idx_w(NQ);
    localparam int BW = idx_w(BURST);

    logic             r_valid;
    logic [DBITS-1:0] r_data;
    logic [IW-1:0]    r_src;
    logic [IW-1:0]    r_ptr;
    logic [BW-1:0]    r_bcnt;

    logic             w_load, w_cont, w_brk, w_go;
    logic             w_all_vld, w_arb_vld, w_sel_vld;
    logic [IW-1:0]    w_all_idx, w_arb_idx, w_sel_idx;

    assign w_load = ena_i && (!r_valid || ready_i);

    rl_rr_arbiter #(.NQ(NQ), .IW(IW)) u_arb_all (
        .i_req         (~q_empty_i),
        .i_ptr         (r_ptr),
        .o_grant_valid (w_all_vld),
        .o_grant_idx   (w_all_idx)
    );

`ifdef RL_QUEUE_SCHED_PRIO_EN
    logic [NQ-1:0] w_hi_req;
    logic          w_hi_vld;
    logic [IW-1:0] w_hi_idx;

    assign w_hi_req = ~q_empty_i & prio_i;

    rl_rr_arbiter #(.NQ(NQ), .IW(IW)) u_arb_hi (
        .i_req         (w_hi_req),
        .i_ptr         (r_ptr),
        .o_grant_valid (w_hi_vld),
        .o_grant_idx   (w_hi_idx)
    );

    // A low-priority burst yields as soon as any high-priority queue has data.
    assign w_brk     = !prio_i[r_ptr] && (|w_hi_req);
    assign w_arb_vld = w_hi_vld | w_all_vld;
    assign w_arb_idx = w_hi_vld ? w_hi_idx : w_all_idx;
`else
    assign w_brk     = 1'b0;
    assign w_arb_vld = w_all_vld;
    assign w_arb_idx = w_all_idx;
`endif

    assign w_cont    = (BURST > 1) && (r_bcnt < BW'(BURST - 1)) && !q_empty_i[r_ptr] && !w_brk;
    assign w_sel_vld = w_cont || w_arb_vld;
    assign w_sel_idx = w_cont ? r_ptr : w_arb_idx;
    assign w_go      = rst_ni && !clr_i && w_load && w_sel_vld;

    always_comb begin
        q_re_o = '0;
        if (w_go) q_re_o[w_sel_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= IW'(NQ - 1);
            r_bcnt  <= '0;
        end else if (w_load) begin
            if (w_sel_vld) begin
                r_valid <= 1'b1;
                r_data  <= q_data_i[w_sel_idx];
                r_src   <= w_sel_idx;
                r_ptr   <= w_sel_idx;
                r_bcnt  <= w_cont ? r_bcnt + BW'(1) : '0;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign src_o   = r_src;

endmodule

// File: tb/tb_rl_queue_sched.sv
// Directed bench: BURST=1 instance (A) and BURST=3 instance (B), each fed by model queues.
module tb_rl_queue_sched;

    localparam int NQ = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, clr, ena, ready, log_clr;
    logic [NQ-1:0]          emp_a, emp_b, re_a, re_b;
    logic [NQ-1:0][DW-1:0]  hd_a, hd_b;
    logic                   val_a, val_b;
    logic [DW-1:0]          dat_a, dat_b;
    logic [1:0]             src_a, src_b;

    rl_queue_sched #(.NQ(NQ), .DBITS(DW), .BURST(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .ena_i(ena),
        .q_empty_i(emp_a), .q_data_i(hd_a), .q_re_o(re_a),
        .valid_o(val_a), .ready_i(ready), .data_o(dat_a), .src_o(src_a)
    );

    rl_queue_sched #(.NQ(NQ), .DBITS(DW), .BURST(3)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .ena_i(ena),
        .q_empty_i(emp_b), .q_data_i(hd_b), .q_re_o(re_b),
        .valid_o(val_b), .ready_i(ready), .data_o(dat_b), .src_o(src_b)
    );

    // Model fall-through queues: wr pointers owned by the stimulus, rd by the pop process.
    logic [DW-1:0] mem [2][NQ][16];
    int wr [2][NQ] = '{default: 0};
    int rd [2][NQ] = '{default: 0};

    always_comb begin
        for (int k = 0; k < NQ; k++) begin
            emp_a[k] = (wr[0][k] == rd[0][k]);
            emp_b[k] = (wr[1][k] == rd[1][k]);
            hd_a[k]  = mem[0][k][rd[0][k] % 16];
            hd_b[k]  = mem[1][k][rd[1][k] % 16];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NQ; k++) begin
            if (re_a[k]) rd[0][k] <= rd[0][k] + 1;
            if (re_b[k]) rd[1][k] <= rd[1][k] + 1;
        end
    end

    // Transfer log and read counters, sampled at the edge where they take effect.
    int nlog_a = 0, nlog_b = 0, nrd_a = 0, nrd_b = 0, bad_rd = 0;
    logic [1:0]    lsrc_a [64], lsrc_b [64];
    logic [DW-1:0] ldat_a [64], ldat_b [64];

    always @(posedge clk) begin
        if ((re_a & emp_a) != 0 || (re_b & emp_b) != 0) bad_rd <= bad_rd + 1;
        if (log_clr) begin
            nlog_a <= 0; nlog_b <= 0; nrd_a <= 0; nrd_b <= 0;
        end else begin
            if (ena && rst_n && !clr && val_a && ready) begin
                lsrc_a[nlog_a % 64] <= src_a; ldat_a[nlog_a % 64] <= dat_a; nlog_a <= nlog_a + 1;
            end
            if (ena && rst_n && !clr && val_b && ready) begin
                lsrc_b[nlog_b % 64] <= src_b; ldat_b[nlog_b % 64] <= dat_b; nlog_b <= nlog_b + 1;
            end
            nrd_a <= nrd_a + $countones(re_a);
            nrd_b <= nrd_b + $countones(re_b);
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input int q, input logic [DW-1:0] v);
        mem[d][q][wr[d][q] % 16] = v;
        wr[d][q] = wr[d][q] + 1;
    endtask

    task automatic clear_log();
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
    endtask

    initial begin
        int c0, c1;
        logic [1:0] bexp [10];
        bexp = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1};

        rst_n = 1'b0; clr = 1'b0; ena = 1'b1; ready = 1'b1; log_clr = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; log_clr = 1'b0;

        // Reset / idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_a", {val_a, re_a, src_a, dat_a}, '0);
            chk("idle_b", {val_b, re_b, src_b, dat_b}, '0);
        end

        // Round-robin, 3 entries per queue
        for (int e = 0; e < 3; e++)
            for (int q = 0; q < NQ; q++) push(0, q, 32'hA0 + q + (e << 8));
        repeat (16) @(negedge clk);
        chk("rr_beats", nlog_a, 12);
        chk("rr_reads", nrd_a, 12);
        chk("rr_valid_drop", val_a, 0);
        for (int i = 0; i < 12; i++) begin
            chk("rr_src", lsrc_a[i], i % 4);
            chk("rr_data", ldat_a[i], 32'hA0 + (i % 4) + ((i / 4) << 8));
        end

        // Backpressure on a single entry in queue 2
        clear_log();
        ready = 1'b0;
        push(0, 2, 32'h55);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", val_a, 1);
            chk("bp_data", dat_a, 32'h55);
            chk("bp_src", src_a, 2);
            chk("bp_re", re_a, 0);
        end
        chk("bp_reads", nrd_a, 1);
        chk("bp_held", nlog_a, 0);
        ready = 1'b1;
        @(negedge clk);
        chk("bp_xfer", nlog_a, 1);
        chk("bp_xdata", ldat_a[0], 32'h55);
        chk("bp_after", val_a, 0);
        chk("bp_reads2", nrd_a, 1);

        // Burst of 3 on instance B
        clear_log();
        for (int e = 0; e < 5; e++) begin
            push(1, 0, 32'hB0 + e);
            push(1, 1, 32'hC0 + e);
        end
        repeat (14) @(negedge clk);
        chk("bu_beats", nlog_b, 10);
        chk("bu_reads", nrd_b, 10);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 10; i++) begin
            chk("bu_src", lsrc_b[i], bexp[i]);
            if (bexp[i] == 2'd0) begin
                chk("bu_data", ldat_b[i], 32'hB0 + c0); c0++;
            end else begin
                chk("bu_data", ldat_b[i], 32'hC0 + c1); c1++;
            end
        end

        // Single entry with pointer at NQ-1
        push(0, 3, 32'h33);
        repeat (3) @(negedge clk);
        clear_log();
        push(0, 1, 32'h11);
        @(negedge clk);
        chk("se_valid", val_a, 1);
        chk("se_src", src_a, 1);
        chk("se_data", dat_a, 32'h11);
        chk("se_re_quiet", re_a, 0);
        @(negedge clk);
        chk("se_drop", val_a, 0);
        repeat (2) @(negedge clk);
        chk("se_reads", nrd_a, 1);
        chk("se_beats", nlog_a, 1);

        // Wrap ordering: pointer at NQ-1, queues 0 and 2 ready together
        push(0, 3, 32'h34);
        repeat (3) @(negedge clk);
        clear_log();
        push(0, 2, 32'h22);
        push(0, 0, 32'h20);
        repeat (4) @(negedge clk);
        chk("wr_beats", nlog_a, 2);
        chk("wr_src0", lsrc_a[0], 0);
        chk("wr_src1", lsrc_a[1], 2);

        // Clear mid-stream (pointer currently 2)
        clear_log();
        push(0, 0, 32'h60); push(0, 0, 32'h61);
        push(0, 3, 32'h63); push(0, 3, 32'h64);
        @(negedge clk);
        chk("cl_src_a", src_a, 3);
        chk("cl_data_a", dat_a, 32'h63);
        @(negedge clk);
        chk("cl_src_b", src_a, 0);
        chk("cl_data_b", dat_a, 32'h60);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("cl_reset", {val_a, src_a, dat_a}, '0);
        @(negedge clk);
        chk("cl_restart_v", val_a, 1);
        chk("cl_restart_src", src_a, 0);
        chk("cl_restart_data", dat_a, 32'h61);
        repeat (3) @(negedge clk);
        chk("cl_beats", nlog_a, 3);
        chk("cl_reads", nrd_a, 4);
        chk("cl_log0", ldat_a[0], 32'h63);
        chk("cl_log1", ldat_a[1], 32'h61);
        chk("cl_log2", ldat_a[2], 32'h64);

        // Clock enable low for 4 cycles with a beat held
        clear_log();
        push(0, 1, 32'h70); push(0, 1, 32'h71); push(0, 1, 32'h72);
        @(negedge clk);
        chk("en_first", dat_a, 32'h70);
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("en_valid", val_a, 1);
            chk("en_data", dat_a, 32'h70);
            chk("en_src", src_a, 1);
            chk("en_re", re_a, 0);
        end
        chk("en_reads_frozen", nrd_a, 1);
        chk("en_beats_frozen", nlog_a, 0);
        ena = 1'b1;
        repeat (5) @(negedge clk);
        chk("en_beats", nlog_a, 3);
        chk("en_reads", nrd_a, 3);
        for (int i = 0; i < 3; i++) chk("en_data_seq", ldat_a[i], 32'h70 + i);

        chk("no_empty_read", bad_rd, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rl_queue_sched.md
Name: rl_queue_sched

Overview:
- Round-robin scheduler that drains NQ fall-through queues into one registered output stream with a valid/ready handshake.
- Watches each queue's empty flag and head data, and drives a one-hot read enable to the selected queue.
- Sits between a bank of rl_queue instances (e.g. per-source request queues) and a single shared consumer such as a memory port or bus master.

Parameters:
- NQ, 4, number of source queues (2+).
- DBITS, 32, data width of each queue entry.
- BURST, 1, maximum consecutive grants to one queue before rotating (1+).

Ports:
- clk_i  input  1  rising-edge clock
- rst_ni  input  1  reset, synchronous, active low
- clr_i  input  1  synchronous clear of all scheduler state
- ena_i  input  1  clock enable
- q_empty_i  input  NQ  empty flags from the source queues
- q_data_i  input  NQ x DBITS  head data (q_o) of each source queue
- q_re_o  output  NQ  one-hot read enable to the source queues (combinational)
- valid_o  output  1  output register holds valid data
- ready_i  input  1  consumer accepts data
- data_o  output  DBITS  registered output data
- src_o  output  $clog2(NQ)  index of the queue data_o came from

Behaviour:
- Reset and clear:
  - Priority is rst_ni low, then clr_i, then ena_i.
  - Reset/clear values: valid_o=0, data_o=0, src_o=0, ptr=NQ-1, burst_cnt=0.
  - q_re_o=0 whenever rst_ni=0, clr_i=1 or ena_i=0.
- Transfer and load:
  - A transfer to the consumer occurs only when ena_i && valid_o && ready_i.
  - A load slot exists when ena_i && (!valid_o || ready_i).
- Selection, evaluated combinationally in each load slot:
  - If BURST>1, burst_cnt<BURST-1 and !q_empty_i[ptr], select ptr again (continue burst).
  - Otherwise select the first non-empty queue scanning ptr+1, ptr+2, ... with wrap modulo NQ, ending at ptr itself.
  - If none is non-empty, there is no selection.
- On a selection at index k:
  - q_re_o[k]=1.
  - Next cycle: data_o<=q_data_i[k], src_o<=k, valid_o<=1, ptr<=k.
  - burst_cnt <= (k==ptr && burst continuing) ? burst_cnt+1 : 0.
- Load slot with no selection: valid_o<=0; data_o and src_o hold.
- Stall: valid_o && !ready_i means no read, and all registers hold.
- Timing: latency from queue head to data_o is 1 cycle. Sustained throughput is 1 beat/cycle while any queue is non-empty and ready_i=1.
- Single-entry drain: empty flags are registered in the queues, so a queue holding 1 entry reports empty the cycle after its read, and no double-read occurs. The scheduler never asserts q_re_o[k] when q_empty_i[k]=1.
- Wrap-around: ptr=NQ-1 scans starting at queue 0.
- NQ not a power of 2: ptr increment wraps explicitly at NQ-1, never via overflow.
- Reset mid-burst: burst_cnt and ptr return to reset values, and any pending output is discarded.

Optional Feature:
- Macro: RL_QUEUE_SCHED_PRIO_EN.
- When defined, an extra port prio_i input NQ marks high-priority queues.
  - Selection first considers non-empty queues with prio_i=1, round-robin from ptr; low-priority queues are considered only if none qualify.
  - A burst to a low-priority queue is broken as soon as any high-priority queue is non-empty.
- When not defined: no prio_i port, pure round-robin with burst as above.

Decomposition:
- Package rl_queue_pkg:
  - function next_rr(mask, ptr, NQ) returning found/index, used by the arbiter.
  - localparam-free helper for idx width: $clog2(NQ>1?NQ:2).
- Sub-module rl_rr_arbiter: combinational find-first-from-pointer over an NQ-bit request mask, returning grant_valid and grant_idx.
  - Instantiated twice under RL_QUEUE_SCHED_PRIO_EN (high and all masks), once otherwise.
- rl_queue_sched holds the registers, burst counter and handshake.

Test Plan:
- Reset/idle: rst_ni=0 for 2 cycles, then all queues empty → valid_o=0, q_re_o=0, data_o=0, src_o=0 for 10 cycles.
- Round-robin: NQ=4, BURST=1, every queue holds 3 entries tagged 0xA0+q, ready_i=1 → src_o sequence 0,1,2,3,0,1,2,3,0,1,2,3; valid_o drops after 12 beats; exactly 12 reads total.
- Backpressure: queue 2 holds 0x55, ready_i=0 for 5 cycles → data_o=0x55 and src_o=2 held; q_re_o=0 after the initial read; one transfer when ready_i goes to 1.
- Burst: BURST=3, queues 0 and 1 each hold 5 entries → src_o 0,0,0,1,1,1,0,0,1,1.
- Single entry and wrap: ptr=3, only queue 1 holds 1 entry → q_re_o=4'b0010 once, then valid_o=0 the following load slot; no second read.
- Clear/enable: clr_i pulse mid-stream → valid_o=0 and ptr reset, so the next grant starts at queue 0. ena_i=0 for 4 cycles with ready_i=1 → no reads, outputs frozen.
